// File: rtl/otter_rf_pkg.sv
// Shared types and default sizes for the OTTER integer register file.
package otter_rf_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int REG_ADDR_W = $clog2(NREGS_DEF);

    typedef logic [XLEN_DEF-1:0]   word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

endpackage

// File: rtl/otter_rf_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx over every register and holds
// rf_busy high until the last one has been zeroed.
module otter_rf_clear_seq
    import otter_rf_pkg::*;
#(
    parameter int NREGS          = NREGS_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int AW            = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST_N,
    output logic          rf_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t state;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clr_idx <= '0;
            if (CLEAR_ON_RESET) begin
                state   <= RF_CLEAR;
                rf_busy <= 1'b1;
            end else begin
                state   <= RF_READY;
                rf_busy <= 1'b0;
            end
        end else begin
            case (state)
                RF_CLEAR: begin
                    // Index wraps to 0 naturally since NREGS is a power of two.
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state   <= RF_READY;
                        rf_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= RF_READY;
                end
            endcase
        end
    end

    // Reset has priority: the array is never written while RST_N is low.
    assign clr_we = RST_N && (state == RF_CLEAR);

endmodule

// File: rtl/otter_reg_file.sv
// OTTER RV32I 32x32 register file with two combinational read ports and a
// post-reset clear sequencer. Define OTTER_RF_BYPASS_EN for write-through forwarding.
module otter_reg_file
    import otter_rf_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int NREGS          = NREGS_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int AW            = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            rf_en,
    input  logic [AW-1:0]   rf_wa,
    input  logic [XLEN-1:0] rf_wd,
    input  logic [AW-1:0]   rf_adr1,
    input  logic [AW-1:0]   rf_adr2,
    output logic [XLEN-1:0] rf_rs1,
    output logic [XLEN-1:0] rf_rs2,
    output logic            rf_busy
);

    logic [XLEN-1:0] mem [NREGS];

    logic            clr_we;
    logic [AW-1:0]   clr_idx;
    logic            wb_we;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            fwd1;
    logic            fwd2;

    otter_rf_clear_seq #(
        .NREGS          (NREGS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .rf_busy (rf_busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // Write-back writes are dropped while clearing, in reset, or aimed at x0.
    assign wb_we = RST_N && !rf_busy && rf_en && (rf_wa != '0);

    always_comb begin
        we = 1'b0;
        wa = rf_wa;
        wd = rf_wd;
        if (clr_we) begin
            we = 1'b1;
            wa = clr_idx;
            wd = '0;
        end else if (wb_we) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

`ifdef OTTER_RF_BYPASS_EN
    assign fwd1 = wb_we && (rf_wa == rf_adr1);
    assign fwd2 = wb_we && (rf_wa == rf_adr2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign rf_rs1 = (rf_busy || rf_adr1 == '0) ? '0 : (fwd1 ? rf_wd : mem[rf_adr1]);
    assign rf_rs2 = (rf_busy || rf_adr2 == '0) ? '0 : (fwd2 ? rf_wd : mem[rf_adr2]);

`ifndef SYNTHESIS
    // Upstream must stall on rf_busy; a write here is silently lost.
    always_ff @(posedge CLK) begin
        if (RST_N && rf_busy) begin
            assert (!rf_en)
            else $warning("otter_reg_file: write to x%0d dropped while clearing", rf_wa);
        end
    end
`endif

endmodule

// File: tb/tb_otter_reg_file.sv
// Directed bench for otter_reg_file: clear sequence, writes, x0, busy drop,
// mid-clear reset and same-cycle read/write behaviour.
module tb_otter_reg_file;
    import otter_rf_pkg::*;

    logic      CLK;
    logic      RST_N;
    logic      rf_en;
    reg_addr_t rf_wa;
    word_t     rf_wd;
    reg_addr_t rf_adr1;
    reg_addr_t rf_adr2;
    word_t     rf_rs1;
    word_t     rf_rs2;
    logic      rf_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    otter_reg_file dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .rf_en   (rf_en),
        .rf_wa   (rf_wa),
        .rf_wd   (rf_wd),
        .rf_adr1 (rf_adr1),
        .rf_adr2 (rf_adr2),
        .rf_rs1  (rf_rs1),
        .rf_rs2  (rf_rs2),
        .rf_busy (rf_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Counts edges until rf_busy falls; 0 means it never fell within budget.
    task automatic count_clear(output int edges);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (!rf_busy) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        RST_N   = 1'b0;
        rf_en   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        rf_adr1 = 5'd0;
        rf_adr2 = 5'd0;

        // Reset two cycles, then clear
        step();
        step();
        check("reset_busy", 32'(rf_busy), 32'd1);
        check("reset_rs1", rf_rs1, 32'h0);
        RST_N = 1'b1;
        count_clear(cnt);
        check("clear_edges", 32'(cnt), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rf_adr1 = 5'(i);
            rf_adr2 = 5'(31 - i);
            #1;
            check($sformatf("cleared_rs1_x%0d", i), rf_rs1, 32'h0);
            check($sformatf("cleared_rs2_x%0d", 31 - i), rf_rs2, 32'h0);
        end

        // Basic write/read
        rf_en = 1'b1; rf_wa = 5'd5; rf_wd = 32'hDEADBEEF;
        step();
        rf_en = 1'b0; rf_adr1 = 5'd5; rf_adr2 = 5'd5;
        #1;
        check("wr5_rs1", rf_rs1, 32'hDEADBEEF);
        check("wr5_rs2", rf_rs2, 32'hDEADBEEF);

        // x0 protection
        rf_en = 1'b1; rf_wa = 5'd0; rf_wd = 32'hFFFFFFFF;
        step();
        rf_en = 1'b0; rf_adr1 = 5'd0; rf_adr2 = 5'd5;
        #1;
        check("x0_rs1", rf_rs1, 32'h0);
        check("x0_keep5", rf_rs2, 32'hDEADBEEF);
        rf_adr1 = 5'd1; rf_adr2 = 5'd31;
        #1;
        check("x0_keep1", rf_rs1, 32'h0);
        check("x0_keep31", rf_rs2, 32'h0);

        // Write during busy is dropped; busy forces reads to 0
        rf_en = 1'b1; rf_wa = 5'd3; rf_wd = 32'h11111111;
        step();
        rf_en = 1'b0; rf_adr1 = 5'd3;
        #1;
        check("pre_wr3", rf_rs1, 32'h11111111);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        rf_adr1 = 5'd5;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 2) check("busy_read0", rf_rs1, 32'h0);
            if (k == 10) begin
                rf_en = 1'b1; rf_wa = 5'd3; rf_wd = 32'h12345678;
            end else if (k == 11) begin
                rf_en = 1'b0;
            end
            if (!rf_busy) begin
                cnt = k;
                break;
            end
        end
        check("busywr_edges", 32'(cnt), 32'd32);
        rf_adr1 = 5'd3;
        #1;
        check("busywr_x3", rf_rs1, 32'h0);

        // Reset mid-clear restarts the sequence
        rf_en = 1'b1; rf_wa = 5'd31; rf_wd = 32'hA5A5A5A5;
        step();
        rf_en = 1'b0; rf_adr1 = 5'd31;
        #1;
        check("pre_wr31", rf_rs1, 32'hA5A5A5A5);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        for (int k = 1; k <= 20; k++) step();
        check("mid_busy20", 32'(rf_busy), 32'd1);
        RST_N = 1'b0;
        step();
        check("mid_rst_busy", 32'(rf_busy), 32'd1);
        RST_N = 1'b1;
        count_clear(cnt);
        check("mid_clear_edges", 32'(cnt), 32'd32);
        check("mid_x31", rf_rs1, 32'h0);

        // Same-cycle read of the register being written
        rf_adr2 = 5'd7;
        rf_en = 1'b1; rf_wa = 5'd7; rf_wd = 32'hCAFEF00D;
        #1;
`ifdef OTTER_RF_BYPASS_EN
        check("rdw_same_cycle", rf_rs2, 32'hCAFEF00D);
`else
        check("rdw_same_cycle", rf_rs2, 32'h0);
`endif
        step();
        rf_en = 1'b0;
        #1;
        check("rdw_after_edge", rf_rs2, 32'hCAFEF00D);

        // x0 never forwards
        rf_en = 1'b1; rf_wa = 5'd0; rf_wd = 32'h55AA55AA; rf_adr1 = 5'd0;
        #1;
        check("x0_no_fwd", rf_rs1, 32'h0);
        step();
        rf_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_reg_file.md
Name: otter_reg_file

Overview:
- 32 x 32-bit integer register file for the OTTER RV32I core.
- Consumer end of the write-back path: takes the selected write-back word, destination address and write enable, and provides two combinational source-operand read ports.
- The array is not reset in place. After reset, a built-in clear sequencer zeroes one register per cycle and holds rf_busy high until it finishes, so upstream logic stalls on rf_busy.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; must be a power of two and at least 2.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = no clear, array contents undefined after reset.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous reset, active-low.
- rf_en  input  1  write enable from the write-back stage.
- rf_wa  input  log2(NREGS)  write address (rd).
- rf_wd  input  XLEN  write-back data from the write-back select.
- rf_adr1  input  log2(NREGS)  read address port 1 (rs1).
- rf_adr2  input  log2(NREGS)  read address port 2 (rs2).
- rf_rs1  output  XLEN  read data port 1, combinational.
- rf_rs2  output  XLEN  read data port 2, combinational.
- rf_busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset: one clock (CLK); RST_N is synchronous and active-low, sampled only on the rising edge of CLK.
- States: CLEAR and READY, plus a clear index clr_idx of log2(NREGS) bits.
- RST_N=0 at an edge, CLEAR_ON_RESET=1: state<=CLEAR, clr_idx<=0.
- RST_N=0 at an edge, CLEAR_ON_RESET=0: state<=READY.
- rf_busy = (state==CLEAR), registered. Reset value: 1 when CLEAR_ON_RESET=1, 0 when CLEAR_ON_RESET=0.
- While RST_N stays low: state and clr_idx hold; the array is not written.
- CLEAR with RST_N=1, at each edge: mem[clr_idx]<=0 and clr_idx<=clr_idx+1.
  - When clr_idx==NREGS-1: state<=READY and clr_idx wraps to 0.
  - Clear therefore takes exactly NREGS edges after reset release.
  - rf_busy falls at the edge that writes mem[NREGS-1].
- Reset re-asserted mid-clear: the sequence restarts from index 0; no partial carry-over.
- READY write: if rf_en=1 and rf_wa!=0, then mem[rf_wa]<=rf_wd at the edge. Write latency is 1 cycle.
- rf_en=1 while busy: the write is silently dropped. This is an upstream error; it is flagged by a simulation assertion, not by hardware.
- Writes to x0 are always ignored.
- Reads: rf_rsN = 0 if rf_adrN==0 or rf_busy=1; otherwise mem[rf_adrN].
- Read-during-write to the same address: returns the old value this cycle and the new value after the edge, unless the bypass option is compiled in.
- rf_adr1==rf_adr2 is legal; both ports return the same value.
- The array is built from plain registers without reset, so it maps to distributed RAM or flops.

Optional Feature:
- Macro: OTTER_RF_BYPASS_EN.
- Defined: write-through forwarding. In READY, when rf_en=1, rf_wa!=0 and rf_wa==rf_adrN, rf_rsN returns rf_wd combinationally in the same cycle. The x0 and busy rules still take priority.
- Undefined: no forwarding. Old data is returned until the edge. The hazard unit must cover the one-cycle gap.

Decomposition:
- Shared package otter_rf_pkg:
  - XLEN_DEF=32, NREGS_DEF=32 and REG_ADDR_W=$clog2(NREGS_DEF).
  - typedef logic [XLEN_DEF-1:0] word_t.
  - typedef logic [REG_ADDR_W-1:0] reg_addr_t.
  - typedef enum logic {RF_CLEAR, RF_READY} rf_state_t.
- Sub-module otter_rf_clear_seq:
  - Contains the FSM and the clr_idx counter.
  - Outputs rf_busy, clr_we and clr_idx.
  - The top level muxes array-write address/data/enable between the clear path and the write-back path.

Test Plan:
- Reset and clear, CLEAR_ON_RESET=1: RST_N low 2 cycles, then high.
  - rf_busy=1 for exactly 32 edges, then 0.
  - Afterwards rf_rs1/rf_rs2 read 0 for every address 0..31.
- Basic write/read: write rf_wa=5, rf_wd=32'hDEADBEEF, then set rf_adr1=5 and rf_adr2=5.
  - Both ports read 32'hDEADBEEF on the cycle after the edge.
- x0 protection: write rf_wa=0, rf_wd=32'hFFFFFFFF.
  - rf_adr1=0 reads 32'h0; no other register changes.
- Write during busy: rf_en=1, rf_wa=3, rf_wd=32'h12345678 asserted during clear cycle 10.
  - After clear, rf_adr1=3 reads 32'h0.
  - The simulation assertion fires.
- Reset mid-clear: drop RST_N at clear cycle 20 for 1 cycle.
  - rf_busy stays 1 and deasserts exactly 32 edges after the second release.
  - Register 31, previously written with 32'hA5A5A5A5, reads 0.
- Bypass: write rf_wa=7, rf_wd=32'hCAFEF00D while rf_adr2=7 in the same cycle.
  - With OTTER_RF_BYPASS_EN: rf_rs2=32'hCAFEF00D that cycle.
  - Without: rf_rs2 shows the prior value, 32'h0, that cycle and 32'hCAFEF00D after the edge.
